// File: rtl/mem_port_arbiter_if.sv
// Native picorv32-style memory port: request fields travel from master to
// slave, the completion pulse and read data travel back.
interface mem_port_arbiter_if;
   logic        valid;
   logic        instr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        ready;
   logic [31:0] rdata;

   // The side that issues requests
   modport master (
      output valid, instr, addr, wdata, wstrb,
      input  ready, rdata
   );

   // The side that services requests
   modport slave (
      input  valid, instr, addr, wdata, wstrb,
      output ready, rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a single native memory port.
// IDLE arbitrates, BUSY forwards the granted request until the memory answers,
// ERR returns an error word when the memory stays silent too long.
module mem_port_arbiter #(
   parameter int          PRIORITY  = 0,             // 0 = round-robin, 1 = m0 wins ties
   parameter int          TIMEOUT   = 16,            // BUSY cycles before ERR, 0 = never
   parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
   input  logic               clk,
   input  logic               reset,
   mem_port_arbiter_if.slave  m0,
   mem_port_arbiter_if.slave  m1,
   mem_port_arbiter_if.master s,
   output logic               grant,
   output logic               busy,
   output logic               timeout_err
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] WAIT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_ERR  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic          grant_q, grant_d;
   logic          last_grant_q, last_grant_d;
   logic [CW-1:0] wait_cnt_q, wait_cnt_d;

   logic [1:0]    req;
   logic          win;
   logic          in_busy;
   logic          in_err;
   logic          done;
   logic [31:0]   resp_data;
   logic          sel_instr;
   logic [31:0]   sel_addr;
   logic [31:0]   sel_wdata;
   logic [3:0]    sel_wstrb;

   assign req     = {m1.valid, m0.valid};
   assign in_busy = (state_q == ST_BUSY);
   assign in_err  = (state_q == ST_ERR);

   // Pick the winner of the current IDLE cycle: a lone requester wins outright,
   // a tie goes to m0 (fixed) or to the requester not served last (round-robin)
   always_comb begin
      win = 1'b0;
      case (req)
         2'b10:   win = 1'b1;
         2'b11:   win = (PRIORITY == 1) ? 1'b0 : ~last_grant_q;
         default: win = 1'b0;
      endcase
   end

   // Next-state, grant and timeout counter
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      wait_cnt_d   = wait_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               grant_d    = win;
               wait_cnt_d = '0;
               state_d    = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (s.ready) begin
               last_grant_d = grant_q;
               state_d      = ST_IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + CW'(1);
               if ((TIMEOUT > 0) && (wait_cnt_q == WAIT_LAST)) begin
                  state_d = ST_ERR;
               end
            end
         end
         ST_ERR: begin
            last_grant_d = grant_q;
            state_d      = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; last_grant starts at 1 so m0 takes the first tie
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         wait_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         wait_cnt_q   <= wait_cnt_d;
      end
   end

   // Forward the granted request and route the response back to its owner.
   // A completion coinciding with reset is suppressed: the access is abandoned.
   always_comb begin
      sel_instr = grant_q ? m1.instr : m0.instr;
      sel_addr  = grant_q ? m1.addr  : m0.addr;
      sel_wdata = grant_q ? m1.wdata : m0.wdata;
      sel_wstrb = grant_q ? m1.wstrb : m0.wstrb;

      s.valid = in_busy;
      s.instr = in_busy ? sel_instr : 1'b0;
      s.addr  = in_busy ? sel_addr  : 32'd0;
      s.wdata = in_busy ? sel_wdata : 32'd0;
      s.wstrb = in_busy ? sel_wstrb : 4'd0;

      done      = ~reset & ((in_busy & s.ready) | in_err);
      resp_data = in_err ? ERR_RDATA : s.rdata;

      m0.ready = done & ~grant_q;
      m1.ready = done &  grant_q;
      m0.rdata = (done & ~grant_q) ? resp_data : 32'd0;
      m1.rdata = (done &  grant_q) ? resp_data : 32'd0;
   end

   assign grant       = grant_q;
   assign busy        = (state_q != ST_IDLE);
   assign timeout_err = in_err & ~reset;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (round-robin and fixed priority),
// each in front of its own 1 KiB word memory that answers one cycle after a
// request and never answers addresses at or above 0x400.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   // requester k = dut*2 + n
   logic [3:0]        m_valid;
   logic [3:0]        m_instr;
   logic [3:0][31:0]  m_addr;
   logic [3:0][31:0]  m_wdata;
   logic [3:0][3:0]   m_wstrb;
   logic [3:0]        m_ready;
   logic [3:0][31:0]  m_rdata;

   logic [1:0]        s_valid;
   logic [1:0]        s_instr;
   logic [1:0][31:0]  s_addr;
   logic [1:0][31:0]  s_wdata;
   logic [1:0][3:0]   s_wstrb;
   logic [1:0]        grant;
   logic [1:0]        busy;
   logic [1:0]        terr;

   int n_checks = 0;
   int n_pass   = 0;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_dut
         mem_port_arbiter_if m0_if ();
         mem_port_arbiter_if m1_if ();
         mem_port_arbiter_if s_if ();

         logic        mem_rdy;
         logic [31:0] mem_rd;
         logic [31:0] mem [256];

         assign m0_if.valid = m_valid[gi*2];
         assign m0_if.instr = m_instr[gi*2];
         assign m0_if.addr  = m_addr[gi*2];
         assign m0_if.wdata = m_wdata[gi*2];
         assign m0_if.wstrb = m_wstrb[gi*2];
         assign m1_if.valid = m_valid[gi*2+1];
         assign m1_if.instr = m_instr[gi*2+1];
         assign m1_if.addr  = m_addr[gi*2+1];
         assign m1_if.wdata = m_wdata[gi*2+1];
         assign m1_if.wstrb = m_wstrb[gi*2+1];
         assign m_ready[gi*2]   = m0_if.ready;
         assign m_rdata[gi*2]   = m0_if.rdata;
         assign m_ready[gi*2+1] = m1_if.ready;
         assign m_rdata[gi*2+1] = m1_if.rdata;

         assign s_valid[gi] = s_if.valid;
         assign s_instr[gi] = s_if.instr;
         assign s_addr[gi]  = s_if.addr;
         assign s_wdata[gi] = s_if.wdata;
         assign s_wstrb[gi] = s_if.wstrb;
         assign s_if.ready  = mem_rdy;
         assign s_if.rdata  = mem_rd;

         initial begin
            for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
            mem[4] = 32'h1122_3344;
         end

         // memory: accepts valid && !ready, answers one cycle later
         always @(posedge clk) begin
            if (reset) begin
               mem_rdy <= 1'b0;
               mem_rd  <= 32'd0;
            end else begin
               mem_rdy <= 1'b0;
               if (s_if.valid && !mem_rdy && (s_if.addr < 32'd1024)) begin
                  mem_rdy <= 1'b1;
                  mem_rd  <= mem[s_if.addr[9:2]];
                  for (int b = 0; b < 4; b++)
                     if (s_if.wstrb[b]) mem[s_if.addr[9:2]][8*b +: 8] <= s_if.wdata[8*b +: 8];
               end
            end
         end

         mem_port_arbiter #(
            .PRIORITY  (gi),
            .TIMEOUT   (16),
            .ERR_RDATA (32'hDEADBEEF)
         ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .m0          (m0_if),
            .m1          (m1_if),
            .s           (s_if),
            .grant       (grant[gi]),
            .busy        (busy[gi]),
            .timeout_err (terr[gi])
         );
      end
   endgenerate

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
   endtask

   // single access by requester n of dut d, memory-backed (answers at cycle 2)
   task automatic do_access(input int d, input int n, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb,
                            input logic instr, input logic [31:0] exp, input logic chk);
      int k  = d*2 + n;
      int ko = d*2 + (1 - n);
      int sv_cyc = -1;
      int rd_cyc = -1;
      logic [31:0] rd = 32'd0;
      @(posedge clk); #1;
      m_valid[k] = 1'b1; m_addr[k] = addr; m_wdata[k] = wdata;
      m_wstrb[k] = wstrb; m_instr[k] = instr;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         check("other_ready", 32'(m_ready[ko]), 32'd0);
         if (s_valid[d]) begin
            if (sv_cyc < 0) sv_cyc = c;
            check("s_addr",  s_addr[d], addr);
            check("s_wdata", s_wdata[d], wdata);
            check("s_wstrb", 32'(s_wstrb[d]), 32'(wstrb));
            check("s_instr", 32'(s_instr[d]), 32'(instr));
         end
         if (m_ready[k]) begin
            rd_cyc = c;
            rd = m_rdata[k];
            break;
         end
      end
      check("lat_svalid", 32'(sv_cyc), 32'd1);
      check("lat_ready", 32'(rd_cyc), 32'd2);
      if (chk) check("rdata", rd, exp);
      $display("txn dut%0d m%0d addr=%08h wdata=%08h wstrb=%b rdata=%08h", d, n, addr, wdata, wstrb, rd);
      @(posedge clk); #1;
      m_valid[k] = 1'b0;
      @(negedge clk);
      check("idle_after", 32'(busy[d]), 32'd0);
   endtask

   // both requesters of dut d hold valid for c0/c1 transactions; seq[i] is the expected owner of completion i
   task automatic contend(input int d, input int c0, input int c1, input logic [7:0] seq, input int n);
      int k0 = d*2;
      int k1 = d*2 + 1;
      int kk = k0;
      int rem0 = c0;
      int rem1 = c1;
      int idx = 0;
      logic prev_done = 1'b0;
      logic g;
      @(posedge clk); #1;
      m_addr[k0] = 32'h40; m_addr[k1] = 32'h80;
      m_wstrb[k0] = 4'd0; m_wstrb[k1] = 4'd0;
      m_instr[k0] = 1'b0; m_instr[k1] = 1'b0;
      m_valid[k0] = (rem0 > 0);
      m_valid[k1] = (rem1 > 0);
      for (int c = 0; c < 200 && (rem0 + rem1) > 0; c++) begin
         @(negedge clk);
         if (prev_done) check("gap_idle", 32'(busy[d]), 32'd0);
         prev_done = 1'b0;
         check("one_ready", 32'(m_ready[k0] & m_ready[k1]), 32'd0);
         if (m_ready[k0] | m_ready[k1]) begin
            g  = m_ready[k1];
            kk = g ? k1 : k0;
            check($sformatf("grant_seq%0d", idx), 32'(g), 32'(seq[idx]));
            check("grant_out", 32'(grant[d]), 32'(g));
            check("rr_rdata", m_rdata[kk], 32'h1000_0000 + (m_addr[kk] >> 2));
            $display("txn dut%0d m%0d addr=%08h rdata=%08h", d, g, m_addr[kk], m_rdata[kk]);
            idx++;
            prev_done = 1'b1;
            if (g) rem1--; else rem0--;
         end
         @(posedge clk); #1;
         if (prev_done) m_addr[kk] = m_addr[kk] + 32'd4;
         m_valid[k0] = (rem0 > 0);
         m_valid[k1] = (rem1 > 0);
      end
      if (prev_done) begin
         @(negedge clk);
         check("gap_idle", 32'(busy[d]), 32'd0);
      end
      check("seq_len", 32'(idx), 32'(n));
   endtask

   initial begin
      int   nbusy;
      logic seen;
      logic early;
      logic stray;

      reset   = 1'b1;
      m_valid = '0; m_instr = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check("rst_grant",  32'(grant[d]),       32'd0);
         check("rst_busy",   32'(busy[d]),        32'd0);
         check("rst_svalid", 32'(s_valid[d]),     32'd0);
         check("rst_terr",   32'(terr[d]),        32'd0);
         check("rst_ready0", 32'(m_ready[d*2]),   32'd0);
         check("rst_ready1", 32'(m_ready[d*2+1]), 32'd0);
      end
      @(posedge clk); #1;
      reset = 1'b0;

      // round-robin with both requesting: 0,1,0,1,0,1
      contend(0, 3, 3, 8'b0010_1010, 6);
      // fixed priority: m0 takes every tie, m1 only once m0 drops
      contend(1, 3, 3, 8'b0011_1000, 6);

      // lone m0 read
      do_access(0, 0, 32'h10, 32'd0, 4'b0000, 1'b1, 32'h1122_3344, 1'b1);
      // m1 half-word write, then read back through m0
      do_access(0, 1, 32'h20, 32'hCAFE_F00D, 4'b0011, 1'b0, 32'd0, 1'b0);
      do_access(0, 0, 32'h20, 32'd0, 4'b0000, 1'b0, 32'h1000_F00D, 1'b1);

      // unanswered address: 16 BUSY cycles then one ERR cycle
      @(posedge clk); #1;
      m_valid[0] = 1'b1; m_addr[0] = 32'h800; m_wstrb[0] = 4'd0; m_instr[0] = 1'b0;
      nbusy = 0; seen = 1'b0; early = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (terr[0]) begin
            seen = 1'b1;
            break;
         end
         if (busy[0]) nbusy++;
         if (m_ready[0]) early = 1'b1;
      end
      check("to_seen",        32'(seen),        32'd1);
      check("to_busy_cycles", 32'(nbusy),       32'd16);
      check("to_early_ready", 32'(early),       32'd0);
      check("to_ready",       32'(m_ready[0]),  32'd1);
      check("to_rdata",       m_rdata[0],       32'hDEAD_BEEF);
      check("to_svalid",      32'(s_valid[0]),  32'd0);
      check("to_other_ready", 32'(m_ready[1]),  32'd0);
      check("to_busy",        32'(busy[0]),     32'd1);
      $display("txn dut0 m0 addr=00000800 timeout rdata=%08h busy_cycles=%0d", m_rdata[0], nbusy);
      @(posedge clk); #1;
      m_valid[0] = 1'b0;
      @(negedge clk);
      check("to_idle_busy", 32'(busy[0]), 32'd0);
      check("to_terr_pulse", 32'(terr[0]), 32'd0);

      // reset while m1 is waiting on an unanswered address
      @(posedge clk); #1;
      m_valid[1] = 1'b1; m_addr[1] = 32'h800; m_wstrb[1] = 4'd0;
      repeat (3) @(negedge clk);
      check("rst_pre_busy",  32'(busy[0]),  32'd1);
      check("rst_pre_grant", 32'(grant[0]), 32'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check("rst_mid_ready", 32'(m_ready[1]), 32'd0);
      @(negedge clk);
      check("rst_svalid_after", 32'(s_valid[0]), 32'd0);
      check("rst_busy_after",   32'(busy[0]),    32'd0);
      check("rst_grant_after",  32'(grant[0]),   32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      m_valid[1] = 1'b0;
      stray = 1'b0;
      repeat (20) begin
         @(negedge clk);
         stray = stray | m_ready[0] | m_ready[1] | terr[0];
      end
      check("rst_quiet", 32'(stray), 32'd0);
      $display("txn dut0 m1 addr=00000800 abandoned by reset");

      // first tie after reset goes to m0
      contend(0, 1, 1, 8'b0000_0010, 2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one picorv32-style native memory port (valid/ready/addr/wdata/wstrb/rdata/instr) between two requesters.
- Typical pairing: CPU core on m0 and a DMA/debug loader on m1, both driving the single 1 KiB testbench/BRAM memory.
- Two-state-plus-error FSM with round-robin or fixed priority.
- Includes a response timeout so an unresponsive slave (e.g. an unmapped MMIO address) cannot hang a requester.

Parameters:
- PRIORITY, 0 — 0 = round-robin between m0/m1; 1 = m0 always wins simultaneous requests.
- TIMEOUT, 16 — BUSY cycles without s_ready before an error response; 0 disables the timeout.
- ERR_RDATA, 32'hDEADBEEF — read data returned on a timeout response.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- mN_valid  input  1  requester N (N=0,1) request; held until mN_ready
- mN_instr  input  1  requester N instruction-fetch flag
- mN_addr  input  32  requester N byte address
- mN_wdata  input  32  requester N write data
- mN_wstrb  input  4  requester N byte strobes; 0 = read
- mN_ready  output  1  one-cycle completion pulse to requester N
- mN_rdata  output  32  read data to requester N
- s_valid  output  1  request to shared memory
- s_instr  output  1  forwarded instr flag
- s_addr  output  32  forwarded address
- s_wdata  output  32  forwarded write data
- s_wstrb  output  4  forwarded strobes
- s_ready  input  1  memory completion pulse
- s_rdata  input  32  memory read data
- grant  output  1  index of current or most recent owner
- busy  output  1  high in BUSY or ERR
- timeout_err  output  1  one-cycle pulse on a timeout response

Behaviour:
- Reset values:
  - State IDLE; last_grant = 1 so m0 wins the first tie; wait_cnt = 0.
  - grant = 0; all ready outputs 0; s_valid = 0; timeout_err = 0; busy = 0.
- IDLE:
  - s_valid = 0; s_* data outputs = 0; mN_ready = 0.
  - If any mN_valid is high, the winner is latched into grant and the state goes to BUSY next cycle.
  - Arbitration: a single requester wins outright. On a tie, PRIORITY=1 picks m0; PRIORITY=0 picks the requester opposite last_grant.
  - Latency is one cycle from valid seen in IDLE to s_valid.
  - s_ready seen in IDLE is ignored.
- BUSY:
  - s_valid and s_instr/addr/wdata/wstrb are driven combinationally from the granted requester. The non-granted requester sees ready = 0 and rdata = 0.
  - When s_ready = 1: m[grant]_ready = 1 and m[grant]_rdata = s_rdata in the same cycle; last_grant <= grant; next state IDLE.
  - A requester that deasserts valid while granted is a protocol error. Behaviour is undefined and not checked.
- Timeout:
  - wait_cnt clears on entry to BUSY and increments each BUSY cycle in which s_ready = 0.
  - When wait_cnt reaches TIMEOUT-1 with s_ready = 0, the next state is ERR.
  - If s_ready arrives in that same cycle, the normal completion wins.
  - wait_cnt width is $clog2(TIMEOUT+1), minimum 1.
- ERR (one cycle), then IDLE:
  - s_valid = 0.
  - m[grant]_ready = 1 with m[grant]_rdata = ERR_RDATA; any write is dropped.
  - timeout_err = 1; last_grant <= grant.
- Back-to-back traffic:
  - The mandatory IDLE cycle after every completion guarantees s_valid drops the cycle after s_ready, matching the memory's "valid && !ready" accept rule.
  - A requester holding valid continuously is re-arbitrated each IDLE cycle. Under PRIORITY=0 with both requesting, grants alternate 0,1,0,1…
- Reset asserted mid-transaction:
  - All state returns to reset values on the next edge; s_valid falls that edge.
  - The in-flight access is abandoned with no ready pulse and no timeout_err.
- busy = (state != IDLE).
- grant holds its value through IDLE.

Test Plan:
- m0 read 0x10 alone, memory returns 0x11223344 one cycle later → s_valid high 1 cycle after m0_valid; m0_ready pulse carries 0x11223344; m1_ready stays 0.
- m0 and m1 both request continuously for 6 transactions, PRIORITY=0 → grant sequence 0,1,0,1,0,1; one IDLE cycle between each pair.
- Same stimulus with PRIORITY=1 → m0 served every transaction while it holds valid; m1 served only after m0 drops valid.
- m1 write addr 0x20, wdata 0xCAFEF00D, wstrb 4'b0011 → s_wstrb = 0011; memory word at 0x20 has only its low half updated; m1_ready pulse.
- Request to addr 0x800 (memory never answers), TIMEOUT=16 → 16 BUSY cycles, then ERR: m0_ready = 1, m0_rdata = 0xDEADBEEF, timeout_err pulse, s_valid low; IDLE next.
- Assert reset during BUSY → s_valid = 0, busy = 0, grant = 0 after the edge; no ready pulse; the next tie after reset goes to m0.
